// File: rtl/rc4_encryptor.sv
// RC4 encryption engine.
// Builds the RC4 state in an external single-port 256x8 S memory (identity
// init followed by the key schedule). It then runs the keystream generator
// over a plaintext ROM and writes the ciphertext into a C RAM.
// All external memories register their address, and their q output is valid
// in the cycle after the address is driven. Every read therefore uses a
// RD/WT substate pair.
module rc4_encryptor #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [23:0]       Secret_Key,
    input  logic              Start,
    input  logic              Finish_ack,
    output logic              Finish,
    output logic              Busy,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] p_address,
    input  logic [7:0]        p_q,
    output logic [ADDR_W-1:0] c_address,
    output logic [7:0]        c_data,
    output logic              c_wren
);

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_K_RD_I,
        ST_K_WT_I,
        ST_K_RD_J,
        ST_K_WT_J,
        ST_K_WR_I,
        ST_K_WR_J,
        ST_P_RD_I,
        ST_P_WT_I,
        ST_P_RD_J,
        ST_P_WT_J,
        ST_P_WR_I,
        ST_P_WR_J,
        ST_P_RD_F,
        ST_P_WT_F,
        ST_P_WR_C,
        ST_DONE
    } state_t;

    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [4:0]  k_q, k_d;
    logic [1:0]  kidx_q, kidx_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [7:0]  f_q, f_d;
    logic [7:0]  pk_q, pk_d;

    logic [7:0]        key_byte;
    logic [ADDR_W-1:0] k_addr;

    assign k_addr = ADDR_W'(k_q);

    // Key byte for the current KSA step (i mod 3, tracked by kidx)
    always_comb begin
        key_byte = key_q[7:0];
        case (kidx_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk the INIT / KSA / PRGA substate sequences
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (Start) state_d = ST_INIT;
            ST_INIT:   if (i_q == 8'hFF) state_d = ST_K_RD_I;
            ST_K_RD_I: state_d = ST_K_WT_I;
            ST_K_WT_I: state_d = ST_K_RD_J;
            ST_K_RD_J: state_d = ST_K_WT_J;
            ST_K_WT_J: state_d = ST_K_WR_I;
            ST_K_WR_I: state_d = ST_K_WR_J;
            ST_K_WR_J: state_d = (i_q == 8'hFF) ? ST_P_RD_I : ST_K_RD_I;
            ST_P_RD_I: state_d = ST_P_WT_I;
            ST_P_WT_I: state_d = ST_P_RD_J;
            ST_P_RD_J: state_d = ST_P_WT_J;
            ST_P_WT_J: state_d = ST_P_WR_I;
            ST_P_WR_I: state_d = ST_P_WR_J;
            ST_P_WR_J: state_d = ST_P_RD_F;
            ST_P_RD_F: state_d = ST_P_WT_F;
            ST_P_WT_F: state_d = ST_P_WR_C;
            ST_P_WR_C: state_d = (k_q == K_LAST) ? ST_DONE : ST_P_RD_I;
            ST_DONE:   if (Finish_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath registers (key, indices, latched S/P values)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            kidx_q <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            f_q    <= '0;
            pk_q   <= '0;
        end else begin
            key_q  <= key_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            kidx_q <= kidx_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
            f_q    <= f_d;
            pk_q   <= pk_d;
        end
    end

    // Datapath next values; all S arithmetic wraps mod 256
    always_comb begin
        key_d  = key_q;
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        kidx_d = kidx_q;
        si_d   = si_q;
        sj_d   = sj_q;
        f_d    = f_q;
        pk_d   = pk_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    key_d  = Secret_Key;
                    i_d    = '0;
                    j_d    = '0;
                    k_d    = '0;
                    kidx_d = '0;
                end
            end
            ST_INIT: begin
                // i wraps 255 -> 0, which leaves KSA starting at i = 0 with j still 0
                i_d = i_q + 8'd1;
            end
            ST_K_WT_I: begin
                si_d = s_q;
                j_d  = j_q + s_q + key_byte;
            end
            ST_K_WT_J: sj_d = s_q;
            ST_K_WR_J: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                if (i_q == 8'hFF) begin
                    j_d = '0;
                    k_d = '0;
                end
            end
            ST_P_RD_I: i_d = i_q + 8'd1;
            ST_P_WT_I: begin
                si_d = s_q;
                j_d  = j_q + s_q;
            end
            ST_P_WT_J: sj_d = s_q;
            ST_P_WT_F: begin
                f_d  = s_q;
                pk_d = p_q;
            end
            ST_P_WR_C: k_d = k_q + 5'd1;
            default: ;
        endcase
    end

    // Memory-interface and status outputs, decoded from the current state
    always_comb begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        p_address = '0;
        c_address = '0;
        c_data    = '0;
        c_wren    = 1'b0;
        Busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        Finish    = (state_q == ST_DONE);
        case (state_q)
            ST_INIT: begin
                s_address = i_q;
                s_data    = i_q;
                s_wren    = 1'b1;
            end
            ST_K_RD_I: s_address = i_q;
            ST_K_RD_J: s_address = j_q;
            ST_K_WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
            end
            ST_K_WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            // The P ROM registers its address every cycle, so k is held on
            // p_address throughout PRGA to keep p_q valid up to WT_F.
            ST_P_RD_I: begin
                s_address = i_q + 8'd1;
                p_address = k_addr;
            end
            ST_P_WT_I, ST_P_WT_J, ST_P_WT_F: p_address = k_addr;
            ST_P_RD_J: begin
                s_address = j_q;
                p_address = k_addr;
            end
            ST_P_WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                p_address = k_addr;
            end
            ST_P_WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                p_address = k_addr;
            end
            ST_P_RD_F: begin
                s_address = si_q + sj_q;
                p_address = k_addr;
            end
            ST_P_WR_C: begin
                p_address = k_addr;
                c_address = k_addr;
                c_data    = f_q ^ pk_q;
                c_wren    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
